serial_complementer: RTL and testbench

SERIAL_COMPLEMENTER -- requirements
Module: serial_complementer

---
 rtl/sercomp_pkg.sv | 35 +++
 rtl/serial_bit_counter.sv | 53 +++++
 rtl/serial_complementer.sv | 143 ++++++++++++++
 tb/tb_serial_complementer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sercomp_pkg.sv
`default_nettype none
// ============================================================================
// Module     : sercomp_pkg
// Description: Shared types for the serial complementer: FSM state encoding,
//              complement-mode encodings and a helper that folds the
//              reserved mode code onto two's complement.
// Revision   : 1.0 - initial release
// ============================================================================
package sercomp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COPY   = 2'b01,
        INVERT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ONES = 2'b01,
        MODE_TWOS = 2'b10
    } mode_e;

    // Code 2'b11 has no meaning of its own and behaves as two's complement.
    function automatic mode_e norm_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b00:   r = MODE_PASS;
            2'b01:   r = MODE_ONES;
            default: r = MODE_TWOS;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bit_counter.sv
`default_nettype none
// ============================================================================
// Module     : serial_bit_counter
// Description: Bit-position counter for a WIDTH-bit serial word.
//              clear marks the current cycle as bit 0 of a new word; when
//              enable is also set that bit is consumed, so the counter moves
//              straight to 1. enable alone advances, wrapping to 0 after the
//              terminal count.
// Ports      : clk    - clock, rising edge
//              reset  - asynchronous active-low reset
//              clear  - current bit is bit 0 of a new word
//              enable - a bit is consumed this cycle
//              tc     - counter currently points at bit WIDTH-1
// Revision   : 1.0 - initial release
// ============================================================================
module serial_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = (count_q == C_LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = enable ? C_ONE : '0;
        end else if (enable) begin
            count_d = tc ? '0 : count_q + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_complementer.sv
`default_nettype none
// ============================================================================
// Module     : serial_complementer
// Description: LSB-first serial pass / ones' / two's complementer with a
//              registered 1-cycle output. Two's complement copies bits up to
//              and including the first 1, then inverts the rest.
//              Optional macro SERCOMP_OVF_EN enables most-negative-value
//              overflow detection on ovf; otherwise ovf is tied to 0.
// Ports      : clk       - clock, rising edge
//              reset     - asynchronous active-low reset
//              x         - serial data bit, LSB first
//              valid_in  - qualifies x, start and mode
//              start     - x is bit 0 of a new word (aborts any word)
//              mode      - 00 pass, 01 ones', 10/11 two's
//              y         - registered result bit
//              valid_out - y is valid
//              last_out  - y is bit WIDTH-1 of the result word
//              ovf       - two's-complement overflow, valid with last_out
//              busy      - a word is in progress
// Revision   : 1.0 - initial release
// ============================================================================
module serial_complementer
    import sercomp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       valid_in,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       y,
    output logic       valid_out,
    output logic       last_out,
    output logic       ovf,
    output logic       busy
);

    state_e state_q, state_d, cur_state;
    mode_e  mode_q,  mode_d,  cur_mode;
    logic   y_q, y_d;
    logic   valid_out_q, valid_out_d;
    logic   last_out_q, last_out_d;
    logic   start_acc, accept, is_last, tc;
    logic   result_bit;

    // A start is honoured in any state; plain bits only inside a word.
    assign start_acc = valid_in && start;
    assign accept    = valid_in && (start || (state_q != IDLE));

    // A start always begins a fresh word in COPY with the newly sampled mode,
    // whether it comes from IDLE or aborts a word in flight.
    assign cur_state = start_acc ? COPY : state_q;
    assign cur_mode  = start_acc ? norm_mode(mode) : mode_q;

    // Bit 0 can never be the last bit since WIDTH >= 2.
    assign is_last = accept && !start_acc && tc;

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_acc),
        .enable (accept),
        .tc     (tc)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        y_d         = y_q;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
        result_bit  = x;

        case (cur_mode)
            MODE_ONES: result_bit = ~x;
            MODE_TWOS: result_bit = (cur_state == INVERT) ? ~x : x;
            default:   result_bit = x;
        endcase

        if (accept) begin
            mode_d      = cur_mode;
            y_d         = result_bit;
            valid_out_d = 1'b1;
            last_out_d  = is_last;
            if (is_last) begin
                state_d = IDLE;
            end else if ((cur_mode == MODE_TWOS) && (cur_state == COPY) && x) begin
                state_d = INVERT;
            end else begin
                state_d = cur_state;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_PASS;
            y_q         <= 1'b0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            y_q         <= y_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
        end
    end

`ifdef SERCOMP_OVF_EN
    logic ovf_q, ovf_d;

    // Still in COPY at the last bit with x=1 means every earlier bit was 0:
    // the input is the most negative value, whose negation overflows.
    always_comb begin
        ovf_d = is_last && (cur_mode == MODE_TWOS) && (cur_state == COPY) && x;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign y         = y_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_complementer.sv
`default_nettype none
// ============================================================================
// Module     : tb_serial_complementer
// Description: Self-checking bench for serial_complementer (WIDTH=8).
//              Expected output bits are queued as each bit is driven and
//              compared as the DUT presents them.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_serial_complementer;

    localparam int W = 8;
    localparam logic [W-1:0] C_MOST_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef SERCOMP_OVF_EN
    localparam bit C_OVF_ON = 1'b1;
`else
    localparam bit C_OVF_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       x;
    logic       valid_in;
    logic       start;
    logic [1:0] mode;
    logic       y;
    logic       valid_out;
    logic       last_out;
    logic       ovf;
    logic       busy;

    typedef struct {
        logic         y;
        logic         last;
        logic         ovf;
        int           idx;
        logic [W-1:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [W-1:0] acc;

    serial_complementer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .valid_in  (valid_in),
        .start     (start),
        .mode      (mode),
        .y         (y),
        .valid_out (valid_out),
        .last_out  (last_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_result(input logic [W-1:0] v, input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'b00:   r = v;
            2'b01:   r = ~v;
            default: r = -v;
        endcase
        return r;
    endfunction

    // Drives nbits of a word (start on bit 0, junk mode afterwards), queuing
    // the expected output of every bit; optionally stalls after one bit.
    task automatic send_word(input logic [W-1:0] value, input logic [1:0] m,
                             input int nbits, input int stall_after, input int stall_cycles);
        logic [W-1:0] res;
        logic         twos;
        exp_t         e;
        twos = (m[1] == 1'b1);
        res  = exp_result(value, m);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            start    = (i == 0);
            mode     = (i == 0) ? m : 2'($urandom);
            x        = value[i];
            e.y    = res[i];
            e.last = (i == W - 1);
            e.ovf  = (i == W - 1) && twos && (value == C_MOST_NEG) && C_OVF_ON;
            e.idx  = i;
            e.word = res;
            sb.push_back(e);
            if (i == stall_after) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                    start    = 1'($urandom);
                    x        = 1'($urandom);
                    mode     = 2'($urandom);
                    @(posedge clk);
                    #1;
                    check("stall_vout", valid_out, 1'b0);
                    check("stall_y", y, res[i]);
                    check("stall_busy", busy, 1'b1);
                end
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        valid_in = 1'b0;
        start    = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        #2;
        check("drain", sb.size(), 0);
    endtask

    // Output monitor / scoreboard.
    initial begin
        exp_t e;
        acc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_vout", valid_out, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("y", y, e.y);
                    check("last_out", last_out, e.last);
                    check("ovf", ovf, e.ovf);
                    acc[e.idx] = y;
                    if (e.last) check("word", acc, e.word);
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        x        = 1'b0;
        valid_in = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, 1'b0);
        check("rst_vout", valid_out, 1'b0);
        check("rst_last", last_out, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Non-start bit in IDLE is ignored.
        @(negedge clk);
        valid_in = 1'b1;
        start    = 1'b0;
        x        = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ignore_vout", valid_out, 1'b0);
        check("idle_ignore_busy", busy, 1'b0);

        // Main function, words back-to-back.
        send_word(8'h06, 2'b10, W, -1, 0);
        send_word(8'h80, 2'b10, W, -1, 0);
        send_word(8'h00, 2'b11, W, -1, 0);
        send_word(8'h0F, 2'b01, W, -1, 0);
        send_word(8'hA5, 2'b00, W, -1, 0);
        send_word(8'hA5, 2'b00, W, -1, 0);
        send_word(8'h3C, 2'b10, W, -1, 0);

        // Stall after bit 2 for 3 cycles.
        send_word(8'h06, 2'b10, W, 2, 3);

        // Abort after 3 bits, restart with 0x01 in two's mode.
        send_word(8'h06, 2'b10, 3, -1, 0);
        send_word(8'h01, 2'b10, W, -1, 0);
        go_idle();
        drain();
        check("idle_busy", busy, 1'b0);

        // Asynchronous reset mid-word, between clock edges.
        send_word(8'h00, 2'b01, 3, -1, 0);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        check("arst_y", y, 1'b0);
        check("arst_vout", valid_out, 1'b0);
        check("arst_last", last_out, 1'b0);
        check("arst_ovf", ovf, 1'b0);
        check("arst_busy", busy, 1'b0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        send_word(8'h06, 2'b10, W, -1, 0);
        go_idle();
        drain();
        check("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
